sram_read_capture: RTL

- Datapath stage directly downstream of the SRAM read-cycle FSM.
- Consumes the FSM strobes `latch`, `count`, `not_oe` and `reading`.
- Drives the SRAM address counter and captures each word the SRAM drives on its data bus.
- Buffers captured words with their addresses in a small FIFO, drained by a valid/ready consumer.

---
 rtl/sram_read_capture.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sram_read_capture.sv
// sram_read_capture: observes the SRAM read-cycle FSM strobes, owns the
// SRAM address counter, captures each word driven on the data bus when
// output enable first goes low, and queues {data, address} pairs in a
// small first-word-fall-through FIFO for a valid/ready consumer.
module sram_read_capture #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              latch,
    input  logic              count,
    input  logic              not_oe,
    input  logic              reading,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  words_read,
    output logic              overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    // Delayed copies of the FSM strobes used for edge detection.
    logic latch_d;
    logic count_d;
    logic not_oe_d;
    logic reading_d;

    logic burst_start;
    logic addr_adv;
    logic capture;
    logic pop;
    logic push_ok;
    logic full;
    logic empty;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    // Burst start only on the first latch rise of a burst; later latch rises
    // inside the same burst (reading_d high) must not reload the address.
    assign burst_start = latch && !latch_d && !reading_d;
    assign addr_adv    = count && !count_d && reading;
    // One capture per OE-low window: only the falling edge of not_oe counts.
    assign capture     = !not_oe && not_oe_d;

    assign empty    = (occ == '0);
    assign full     = (occ == OCC_W'(DEPTH));
    assign pop      = !empty && rd_ready;
    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign push_ok  = capture && (!full || pop);

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : data_mem[rd_ptr];
    assign rd_addr  = empty ? '0 : addr_mem[rd_ptr];

    // Register strobe history; count/not_oe idle high so reset creates no false edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_d   <= 1'b0;
            count_d   <= 1'b1;
            not_oe_d  <= 1'b1;
            reading_d <= 1'b0;
        end else begin
            latch_d   <= latch;
            count_d   <= count;
            not_oe_d  <= not_oe;
            reading_d <= reading;
        end
    end

    // SRAM address counter: burst start reload has priority over advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_addr <= '0;
        end else if (burst_start) begin
            sram_addr <= start_addr;
        end else if (addr_adv) begin
            sram_addr <= sram_addr + ADDR_W'(1);
        end
    end

    // Capture statistics: every capture counts, dropped ones set the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_read <= '0;
            overflow   <= 1'b0;
        end else begin
            if (capture) begin
                words_read <= words_read + CNT_W'(1);
            end
            if (capture && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push_ok) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers make them visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr] <= sram_dq_in;
            addr_mem[wr_ptr] <= sram_addr;
        end
    end

endmodule
